// File: rtl/wm_led_pkg.sv
// Shared definitions for the washing-machine front-panel LED controller.
//   state_t      : controller FSM state (IDLE / RUN / DONE)
//   idx_width()  : index width helper, clog2 with a minimum of 1 bit
//   DEF_CLK_HZ   : default system clock frequency (125 MHz)
//   DEF_BLINK_HZ : default blink frequency of the active stage LED
package wm_led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_CLK_HZ   = 125000000;
  localparam int DEF_BLINK_HZ = 2;

  // Width needed to index n items; never less than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wm_blink_gen.sv
// Blink prescaler and phase generator.
// The counter runs 0..HALF-1 continuously; phase toggles each time it wraps.
// A restart pulse clears the counter and forces phase high, so a freshly
// activated LED is lit in its very first cycle.
// Ports:
//   clk        in  system clock
//   reset      in  asynchronous active-high reset (counter 0, phase 0)
//   restart    in  synchronous restart: counter 0, phase 1
//   phase      out registered blink phase
//   phase_next out value phase takes at the next edge
//   wrap       out counter is at HALF-1 (a half period ends this cycle);
//                  independent of restart so callers can use it freely
module wm_blink_gen #(
  parameter int HALF = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic phase,
  output logic phase_next,
  output logic wrap
);

  localparam int CW = (HALF <= 2) ? 1 : $clog2(HALF);
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          phase_reg;

  assign wrap = (cnt_reg == LAST);

  always_comb begin
    cnt_next   = cnt_reg + 1'b1;
    phase_next = phase_reg;
    if (restart) begin
      cnt_next   = '0;
      phase_next = 1'b1;
    end else if (wrap) begin
      cnt_next   = '0;
      phase_next = ~phase_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg   <= '0;
      phase_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      phase_reg <= phase_next;
    end
  end

  assign phase = phase_reg;

endmodule

// File: rtl/wm_led_panel.sv
// Washing-machine front-panel LED controller.
// Holds the stage / water-level / temperature selections, blinks the running
// stage LED and plays a completion blink sequence before returning to idle.
// Optional build macro: WM_LED_PWM_EN adds parameter PWM_DUTY and dims the
// green LEDs with a free-running 4-bit PWM (on while count < PWM_DUTY).
// Ports:
//   clk             in  system clock
//   reset           in  asynchronous active-high reset
//   btn_stage       in  per-stage toggle pulses (IDLE only)
//   btn_level       in  rotate water-level selection (IDLE only)
//   btn_temp        in  rotate temperature selection (IDLE only)
//   start           in  begin programme (IDLE, needs a selected stage)
//   stop            in  abort programme (RUN / DONE)
//   stage_done      in  sequencer: current stage finished
//   red_led_stage   out stage LEDs
//   red_led_run     out high while running
//   green_led_level out one-hot water level
//   green_led_temp  out one-hot temperature
//   cur_stage       out index of the active stage
//   busy            out high in RUN or DONE
// All outputs are registered from next-state values (1-cycle latency).
module wm_led_panel
  import wm_led_pkg::*;
#(
  parameter int CLK_HZ      = DEF_CLK_HZ,
  parameter int BLINK_HZ    = DEF_BLINK_HZ,
  parameter int N_STAGE     = 3,
  parameter int N_LEVEL     = 3,
  parameter int N_TEMP      = 3,
  parameter int DONE_BLINKS = 4
`ifdef WM_LED_PWM_EN
  ,
  parameter int PWM_DUTY    = 4
`endif
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_STAGE-1:0]            btn_stage,
  input  logic                          btn_level,
  input  logic                          btn_temp,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          stage_done,
  output logic [N_STAGE-1:0]            red_led_stage,
  output logic                          red_led_run,
  output logic [N_LEVEL-1:0]            green_led_level,
  output logic [N_TEMP-1:0]             green_led_temp,
  output logic [idx_width(N_STAGE)-1:0] cur_stage,
  output logic                          busy
);

  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int SW   = idx_width(N_STAGE);
  localparam int DW   = idx_width(2 * DONE_BLINKS);
  // DONE ends on the last half-period wrap of DONE_BLINKS full periods.
  localparam logic [DW-1:0]      DONE_LAST  = DW'(2 * DONE_BLINKS - 1);
  localparam logic [N_LEVEL-1:0] LEVEL_INIT = {{(N_LEVEL-1){1'b0}}, 1'b1};
  localparam logic [N_TEMP-1:0]  TEMP_INIT  = {{(N_TEMP-1){1'b0}}, 1'b1};

  state_t             state_reg, state_next;
  logic [SW-1:0]      cur_reg, cur_next;
  logic [N_STAGE-1:0] sel_reg, sel_next;
  logic [N_LEVEL-1:0] level_reg, level_next;
  logic [N_TEMP-1:0]  temp_reg, temp_next;
  logic [DW-1:0]      done_cnt_reg, done_cnt_next;
  logic [N_STAGE-1:0] red_reg, red_next;
  logic               run_reg, busy_reg;

  logic               restart;
  logic               phase, phase_next, wrap;
  logic [SW-1:0]      first_idx, next_idx;
  logic               has_next;

  wm_blink_gen #(
    .HALF(HALF)
  ) u_blink (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .phase     (phase),
    .phase_next(phase_next),
    .wrap      (wrap)
  );

  // Lowest selected stage, and lowest selected stage above the current one.
  // Scanning downward lets the last hit be the lowest index.
  always_comb begin
    first_idx = '0;
    next_idx  = '0;
    has_next  = 1'b0;
    for (int i = N_STAGE - 1; i >= 0; i--) begin
      if (sel_reg[i]) begin
        first_idx = SW'(i);
        if (i > int'(cur_reg)) begin
          next_idx = SW'(i);
          has_next = 1'b1;
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next    = state_reg;
    cur_next      = cur_reg;
    sel_next      = sel_reg;
    level_next    = level_reg;
    temp_next     = temp_reg;
    done_cnt_next = done_cnt_reg;
    restart       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          // start swallows any simultaneous button presses
          if (sel_reg != '0) begin
            state_next = ST_RUN;
            cur_next   = first_idx;
            restart    = 1'b1;
          end
        end else begin
          sel_next = sel_reg ^ btn_stage;
          if (btn_level)
            level_next = {level_reg[N_LEVEL-2:0], level_reg[N_LEVEL-1]};
          if (btn_temp)
            temp_next = {temp_reg[N_TEMP-2:0], temp_reg[N_TEMP-1]};
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_next = ST_IDLE;
        end else if (stage_done) begin
          restart = 1'b1;
          if (has_next) begin
            cur_next = next_idx;
          end else begin
            state_next    = ST_DONE;
            done_cnt_next = '0;
          end
        end
      end
      ST_DONE: begin
        if (stop) begin
          state_next = ST_IDLE;
        end else if (wrap) begin
          if (done_cnt_reg == DONE_LAST)
            state_next = ST_IDLE;
          else
            done_cnt_next = done_cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Stage LED pattern for the upcoming cycle.
  always_comb begin
    red_next = sel_next;
    case (state_next)
      ST_RUN: begin
        for (int i = 0; i < N_STAGE; i++) begin
          if (i == int'(cur_next))
            red_next[i] = phase_next;
          else if (i > int'(cur_next))
            red_next[i] = sel_next[i];
          else
            red_next[i] = 1'b0;
        end
      end
      ST_DONE: red_next = {N_STAGE{phase_next}};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cur_reg      <= '0;
      sel_reg      <= '1;
      level_reg    <= LEVEL_INIT;
      temp_reg     <= TEMP_INIT;
      done_cnt_reg <= '0;
      red_reg      <= '1;
      run_reg      <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cur_reg      <= cur_next;
      sel_reg      <= sel_next;
      level_reg    <= level_next;
      temp_reg     <= temp_next;
      done_cnt_reg <= done_cnt_next;
      red_reg      <= red_next;
      run_reg      <= (state_next == ST_RUN);
      busy_reg     <= (state_next != ST_IDLE);
    end
  end

  assign red_led_stage = red_reg;
  assign red_led_run   = run_reg;
  assign cur_stage     = cur_reg;
  assign busy          = busy_reg;

`ifdef WM_LED_PWM_EN
  localparam logic [4:0] PWM_DUTY_5 = 5'(PWM_DUTY);

  logic [3:0]         pwm_cnt_reg;
  logic [3:0]         pwm_cnt_next;
  logic               pwm_on_next;
  logic [N_LEVEL-1:0] green_level_reg;
  logic [N_TEMP-1:0]  green_temp_reg;

  assign pwm_cnt_next = pwm_cnt_reg + 4'd1;
  assign pwm_on_next  = ({1'b0, pwm_cnt_next} < PWM_DUTY_5);

  // Green registers hold level/temp gated by the PWM phase of the counter
  // value they are loaded alongside.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt_reg     <= '0;
      green_level_reg <= LEVEL_INIT & {N_LEVEL{PWM_DUTY_5 != 5'd0}};
      green_temp_reg  <= TEMP_INIT & {N_TEMP{PWM_DUTY_5 != 5'd0}};
    end else begin
      pwm_cnt_reg     <= pwm_cnt_next;
      green_level_reg <= level_next & {N_LEVEL{pwm_on_next}};
      green_temp_reg  <= temp_next & {N_TEMP{pwm_on_next}};
    end
  end

  assign green_led_level = green_level_reg;
  assign green_led_temp  = green_temp_reg;
`else
  assign green_led_level = level_reg;
  assign green_led_temp  = temp_reg;
`endif

endmodule

// File: tb/tb_wm_led_panel.sv
// Directed testbench for wm_led_panel (CLK_HZ=16, BLINK_HZ=2 -> HALF=4,
// N_STAGE=3, DONE_BLINKS=2). Inputs change 1 ns after a rising edge and
// outputs are sampled at that same point, i.e. after the edge settled.
module tb_wm_led_panel;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] btn_stage;
  logic       btn_level;
  logic       btn_temp;
  logic       start;
  logic       stop;
  logic       stage_done;
  logic [2:0] red_led_stage;
  logic       red_led_run;
  logic [2:0] green_led_level;
  logic [2:0] green_led_temp;
  logic [1:0] cur_stage;
  logic       busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #4 clk = ~clk;

  wm_led_panel #(
    .CLK_HZ     (16),
    .BLINK_HZ   (2),
    .N_STAGE    (3),
    .N_LEVEL    (3),
    .N_TEMP     (3),
    .DONE_BLINKS(2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_stage      (btn_stage),
    .btn_level      (btn_level),
    .btn_temp       (btn_temp),
    .start          (start),
    .stop           (stop),
    .stage_done     (stage_done),
    .red_led_stage  (red_led_stage),
    .red_led_run    (red_led_run),
    .green_led_level(green_led_level),
    .green_led_temp (green_led_temp),
    .cur_stage      (cur_stage),
    .busy           (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one-cycle pulses, then return 1 ns after the edge that took them.
  task automatic pulse(input logic [2:0] bs, input logic bl, input logic bt,
                       input logic st, input logic sp, input logic sd);
    btn_stage  = bs;
    btn_level  = bl;
    btn_temp   = bt;
    start      = st;
    stop       = sp;
    stage_done = sd;
    tick();
    btn_stage  = '0;
    btn_level  = 1'b0;
    btn_temp   = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    stage_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] exp_level [3];
    exp_level[0] = 3'b010;
    exp_level[1] = 3'b100;
    exp_level[2] = 3'b001;
    reset = 1'b1;
    btn_stage = '0; btn_level = 0; btn_temp = 0; start = 0; stop = 0; stage_done = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    total_cnt++;
    if ({red_led_stage, green_led_level, green_led_temp} !== 9'b111_001_001)
      $display("FAIL reset_leds got red=%b lvl=%b tmp=%b expected red=111 lvl=001 tmp=001",
               red_led_stage, green_led_level, green_led_temp);
    else pass_cnt++;
    total_cnt++;
    if ({busy, red_led_run, cur_stage} !== 4'b0000)
      $display("FAIL reset_status got busy=%b run=%b cur=%0d expected busy=0 run=0 cur=0",
               busy, red_led_run, cur_stage);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      pulse(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      total_cnt++;
      if (green_led_level !== exp_level[i])
        $display("FAIL level_rotate step=%0d got %b expected %b", i, green_led_level, exp_level[i]);
      else pass_cnt++;
    end
  endtask

  // Deselect stage 1, start, and watch stage 0 blink with stage 2 steady.
  task automatic test_run_blink();
    logic [2:0] exp;
    pulse(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (red_led_stage !== 3'b101)
      $display("FAIL idle_sel got %b expected 101", red_led_stage);
    else pass_cnt++;
    pulse(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if ({busy, red_led_run, cur_stage} !== 4'b1100)
      $display("FAIL run_entry got busy=%b run=%b cur=%0d expected busy=1 run=1 cur=0",
               busy, red_led_run, cur_stage);
    else pass_cnt++;
    for (int k = 0; k < 12; k++) begin
      exp = {1'b1, 1'b0, ((k / 4) % 2 == 0)};
      total_cnt++;
      if (red_led_stage !== exp)
        $display("FAIL run_blink cycle=%0d got %b expected %b", k, red_led_stage, exp);
      else pass_cnt++;
      tick();
    end
  endtask

  // Advance past deselected stage 1 to stage 2, then through DONE.
  task automatic test_stage_advance_done();
    logic [2:0] exp;
    pulse(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (cur_stage !== 2'd2)
      $display("FAIL advance_skip got cur=%0d expected 2", cur_stage);
    else pass_cnt++;
    for (int k = 0; k < 8; k++) begin
      exp = {((k / 4) % 2 == 0), 2'b00};
      total_cnt++;
      if (red_led_stage !== exp)
        $display("FAIL stage2_blink cycle=%0d got %b expected %b", k, red_led_stage, exp);
      else pass_cnt++;
      if (k < 7) tick();
    end
    pulse(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    total_cnt++;
    if ({busy, red_led_run} !== 2'b10)
      $display("FAIL done_entry got busy=%b run=%b expected busy=1 run=0", busy, red_led_run);
    else pass_cnt++;
    for (int k = 0; k < 16; k++) begin
      exp = ((k / 4) % 2 == 0) ? 3'b111 : 3'b000;
      total_cnt++;
      if (red_led_stage !== exp)
        $display("FAIL done_blink cycle=%0d got %b expected %b", k, red_led_stage, exp);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if ({busy, red_led_stage} !== 4'b0101)
      $display("FAIL done_exit got busy=%b red=%b expected busy=0 red=101", busy, red_led_stage);
    else pass_cnt++;
  endtask

  // Empty selection ignores start; start beats a simultaneous btn_temp.
  task automatic test_start_rules();
    pulse(3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (red_led_stage !== 3'b000)
      $display("FAIL empty_sel got %b expected 000", red_led_stage);
    else pass_cnt++;
    pulse(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if ({busy, red_led_run} !== 2'b00)
      $display("FAIL empty_start got busy=%b run=%b expected busy=0 run=0", busy, red_led_run);
    else pass_cnt++;
    pulse(3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if ({red_led_stage, green_led_temp} !== 6'b011_010)
      $display("FAIL idle_edit got red=%b tmp=%b expected red=011 tmp=010", red_led_stage, green_led_temp);
    else pass_cnt++;
    pulse(3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if ({busy, cur_stage, green_led_temp, red_led_stage} !== 9'b1_00_010_011)
      $display("FAIL start_priority got busy=%b cur=%0d tmp=%b red=%b expected busy=1 cur=0 tmp=010 red=011",
               busy, cur_stage, green_led_temp, red_led_stage);
    else pass_cnt++;
  endtask

  // stop beats stage_done; buttons during RUN do nothing.
  task automatic test_stop_and_freeze();
    pulse(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if ({busy, red_led_stage, green_led_level, green_led_temp} !== 10'b0_011_001_010)
      $display("FAIL stop_priority got busy=%b red=%b lvl=%b tmp=%b expected busy=0 red=011 lvl=001 tmp=010",
               busy, red_led_stage, green_led_level, green_led_temp);
    else pass_cnt++;
    pulse(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse(3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if ({busy, red_led_stage, green_led_level} !== 7'b1_011_001)
      $display("FAIL run_freeze got busy=%b red=%b lvl=%b expected busy=1 red=011 lvl=001",
               busy, red_led_stage, green_led_level);
    else pass_cnt++;
    pulse(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    total_cnt++;
    if ({busy, red_led_stage} !== 4'b0011)
      $display("FAIL run_stop got busy=%b red=%b expected busy=0 red=011", busy, red_led_stage);
    else pass_cnt++;
  endtask

  // Reset mid-RUN takes effect before the next clock edge.
  task automatic test_async_reset();
    pulse(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    #1 reset = 1'b1;
    #1;
    total_cnt++;
    if ({red_led_stage, red_led_run, busy, cur_stage, green_led_level, green_led_temp} !== 13'b111_0_0_00_001_001)
      $display("FAIL async_reset got red=%b run=%b busy=%b cur=%0d lvl=%b tmp=%b expected red=111 run=0 busy=0 cur=0 lvl=001 tmp=001",
               red_led_stage, red_led_run, busy, cur_stage, green_led_level, green_led_temp);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick();
    total_cnt++;
    if ({red_led_stage, busy} !== 4'b1110)
      $display("FAIL post_reset_idle got red=%b busy=%b expected red=111 busy=0", red_led_stage, busy);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_run_blink();
    test_stage_advance_done();
    test_start_rules();
    test_stop_and_freeze();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wm_led_panel.md
Name: wm_led_panel

Overview:
Parametrised washing-machine front-panel LED controller, successor to the fixed-wiring wm_led_top LED block.
- Holds the user's stage, water-level and temperature selections, edited by single-cycle button pulses.
- Drives red and green LED vectors; the running stage blinks and a completion blink sequence plays at the end.
- Sits between the debounced button front-end and the wash sequencer, which supplies start/stop/stage_done.

Parameters:
CLK_HZ, 125000000, clock frequency in Hz (8 ns period).
BLINK_HZ, 2, blink frequency of the active stage LED.
N_STAGE, 3, number of wash stages (wash/rinse/dry); 1..8.
N_LEVEL, 3, number of water-level options (low/mid/high); 2..8.
N_TEMP, 3, number of temperature options (cold/hot/hot+cold); 2..8.
DONE_BLINKS, 4, full blink periods shown in DONE before returning to IDLE.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
btn_stage  in  N_STAGE  one-cycle pulses; bit i toggles selection of stage i
btn_level  in  1  one-cycle pulse; rotates water-level selection
btn_temp  in  1  one-cycle pulse; rotates temperature selection
start  in  1  one-cycle pulse; begin the programme
stop  in  1  one-cycle pulse; abort the programme
stage_done  in  1  one-cycle pulse from sequencer; current stage finished
red_led_stage  out  N_STAGE  stage LEDs
red_led_run  out  1  high while in RUN
green_led_level  out  N_LEVEL  one-hot water level
green_led_temp  out  N_TEMP  one-hot temperature
cur_stage  out  clog2(N_STAGE) max 1  index of the active stage
busy  out  1  high in RUN or DONE

Behaviour:
- Reset values: stage_sel all ones; level = one-hot bit 0; temp = one-hot bit 0; state IDLE; cur_stage 0; blink counter 0; phase 0.
- Outputs after reset: red_led_stage all ones; red_led_run 0; busy 0.
- All outputs are registered. Input-to-output latency is 1 cycle.
- Blink timing: HALF = CLK_HZ/(2*BLINK_HZ) cycles. The counter counts 0..HALF-1; phase toggles on wrap.
- Entering RUN, or advancing to a new stage, clears the counter and sets phase=1, so the LED is lit in the first cycle.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - btn_stage[i] toggles stage_sel[i].
  - btn_level rotates the level one-hot left (MSB wraps to bit 0); btn_temp does the same for temp.
  - red_led_stage = stage_sel, steady.
  - start with stage_sel != 0 -> RUN; cur_stage = lowest selected index.
  - start with stage_sel == 0 is ignored.
  - start has priority: any buttons in the same cycle are dropped.
  - stop and stage_done are ignored.
- RUN:
  - All buttons are ignored; selections are frozen.
  - red_led_stage[cur_stage] = phase.
  - Selected stages with a higher index than cur_stage are steady on; all other stage LEDs are off.
  - stage_done -> cur_stage = next selected index above cur_stage; if none exists -> DONE.
  - stop -> IDLE with selections preserved. stop wins over a simultaneous stage_done.
  - start is ignored.
- DONE:
  - red_led_stage = {N_STAGE{phase}}, counter restarted on entry with phase=1.
  - After DONE_BLINKS full periods -> IDLE.
  - stop -> IDLE immediately. Other inputs are ignored.
- Green LEDs show level/temp in every state.
- reset asserted mid-operation returns everything to reset values asynchronously, with no completion sequence.

Optional Feature:
WM_LED_PWM_EN
- When defined: adds parameter PWM_DUTY (default 4 of 16). The green LED outputs are ANDed with a free-running 4-bit PWM compare (cnt < PWM_DUTY) for dimming. The PWM counter resets to 0.
- When undefined: green LEDs are driven steady, and no PWM logic or parameter exists.

Decomposition:
- Package wm_led_pkg: FSM state enum (IDLE/RUN/DONE), the width helper function for clog2, and the default CLK_HZ/BLINK_HZ constants.
- One sub-module, wm_blink_gen: prescaler and phase generator with a synchronous restart input and HALF parameter, instantiated once.

Test Plan:
All scenarios use CLK_HZ=16, BLINK_HZ=2 (HALF=4), N_STAGE=3, DONE_BLINKS=2.
1. Release reset -> red_led_stage=3'b111, green_led_level=3'b001, green_led_temp=3'b001, busy=0. Then btn_level x3 -> level 010, 100, 001 (wrap).
2. btn_stage=3'b010, then start -> state RUN, cur_stage=0. red_led_stage toggles bit0 every 4 cycles, first cycle 1; bit2 steady 1; bit1 0.
3. From case 2, stage_done -> cur_stage=2 (skips deselected stage 1). stage_done again -> DONE: all LEDs blink for 16 cycles, then IDLE with red_led_stage=3'b101.
4. stage_sel=0 (btn_stage=3'b111), then start -> remains IDLE, busy=0. Also: start coinciding with btn_temp -> RUN, temp unchanged.
5. In RUN, stop and stage_done asserted in the same cycle -> IDLE with selections retained. In a separate run, btn_stage during RUN -> no change.
6. Assert reset for 3 cycles mid-RUN -> outputs return to reset values asynchronously (before the next clk edge). Build with WM_LED_PWM_EN and PWM_DUTY=4 -> green LED high for 4 of every 16 cycles.
